fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised program-counter unit for the fetch stage: holds the architectural PC register and selects the next fetch address from sequential, branch, jump and exception sources. It generalises the two-input PC mux with configurable width and vectors, stall handling, a pending-redirect buffer for redirects that arrive during a stall, and misaligned-target trapping. It drives the instruction-memory address and the PC+4 value passed down the pipeline.

## Interface
- ADDR_W, 32, PC width in bits (≥ 8)
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- EXC_VECTOR, 32'h8000_0180, exception/trap target
- INC, 4, sequential increment (power of two)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC (downstream not ready)
- branch_taken  in  1  branch redirect request, one-cycle pulse
- branch_address  in  ADDR_W  branch target
- jump_taken  in  1  jump redirect request, one-cycle pulse
- jump_address  in  ADDR_W  jump target
- exception  in  1  exception request, one-cycle pulse
- pc  out  ADDR_W  current fetch address, registered
- pc_plus_4  out  ADDR_W  pc + INC, combinational from pc
- fetch_valid  out  1  pc is a valid fetch address this cycle
- misaligned  out  1  one-cycle pulse: a redirect target was misaligned and trapped

## Operation
- Source priority, highest first: exception, branch, jump, pending redirect, sequential (pc + INC).
- Misaligned: target bits [log2(INC)-1:0] ≠ 0. Winning branch/jump with a misaligned target is replaced by EXC_VECTOR and misaligned pulses the next cycle.
- Exception acts regardless of stall: pc ← EXC_VECTOR next cycle; pending is cleared.
- Stall without exception: pc holds. A branch/jump during a stall is stored in the pending register (pend_valid, pend_addr). A later higher-priority redirect in the same stall overwrites it; a lower-priority one is dropped. A misaligned target is stored as EXC_VECTOR with a pend_mis flag.
- When stall deasserts with pending valid and no new request, pc ← pend_addr, pend_valid clears, and misaligned pulses if pend_mis is set.
- A new branch/jump in the release cycle beats the pending entry; pending is discarded.
- Arithmetic is modulo 2^ADDR_W: pc + INC wraps from all-ones to 0 with no flag.
- FSM states:
  - S_BOOT: in reset.
  - S_RUN: normal.
  - S_HOLD: stalled with pending valid.
- FSM transitions:
  - S_BOOT → S_RUN on the first cycle after reset drops.
  - S_RUN → S_HOLD on stall with a branch/jump.
  - S_HOLD → S_RUN on stall low or exception.
  - Any state → S_BOOT on reset.

## Timing
- Reset values: pc = RESET_VECTOR, fetch_valid = 0, misaligned = 0, pending cleared, state S_BOOT.
- fetch_valid = 1 from the first cycle after reset deasserts, and stays 1 except while reset is asserted.
- Redirect latency: a request in cycle N gives the new pc in cycle N+1 (one-cycle redirect).
- Stall: pc is stable in every cycle stall = 1. Release: the pending target appears in the cycle after stall falls.
- Reset mid-operation overrides everything, including exception and pending, in the same edge.
- Simultaneous branch and jump: branch wins and the jump is lost, with no pending entry.

## Structure
- Shared package fetch_pkg holds:
  - ADDR_W, RESET_VECTOR, EXC_VECTOR and INC defaults.
  - The state enum S_BOOT/S_RUN/S_HOLD.
  - Source-select encoding SEL_EXC/SEL_BR/SEL_JMP/SEL_PEND/SEL_SEQ.
- One sub-module, pc_next_sel, is natural: a combinational priority select plus misalignment check. It outputs the select code, the next address and a misaligned flag.
- The top level holds the pc register, the pending register and the FSM.

## Test plan
- Reset, then run 3 free cycles → pc = 0x0 while reset is asserted; then 0x4, 0x8, 0xC; fetch_valid 0→1 on the first cycle after reset drops.
- branch_taken with branch_address = 0x100 at pc = 0x8 → next pc = 0x100, then 0x104.
- Stall held 3 cycles with jump_address = 0x200 mid-stall, then release → pc constant for 3 cycles; pc = 0x200 one cycle after release.
- Same cycle: branch 0x300, jump 0x400, exception → pc = 0x8000_0180; pending empty.
- branch_address = 0x102 → pc = 0x8000_0180 and misaligned = 1 for one cycle.
- ADDR_W = 8, pc = 0xFC free-running → next pc = 0x00, no trap; reset asserted while in S_HOLD → pc = RESET_VECTOR and pending cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Purpose: shared defaults, FSM state and next-pc source encodings for the fetch PC unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int          ADDR_W_DEF       = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam int          INC_DEF          = 4;

  // S_BOOT: in reset; S_RUN: normal fetch; S_HOLD: stalled with a redirect parked.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Winning next-pc source, listed highest priority first.
  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_PEND = 3'd3,
    SEL_SEQ  = 3'd4
  } sel_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Purpose: redirect requests into, and fetch address out of, the fetch PC unit.
// Latency: n/a (wires only).
// Backpressure: stall from the consumer holds the pc; redirects during a stall are parked.
// Ports: stall, branch_taken/branch_address, jump_taken/jump_address, exception
//        (requester -> unit); pc, pc_plus_4, fetch_valid, misaligned (unit -> requester).
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 32
);

  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_address;
  logic              jump_taken;
  logic [ADDR_W-1:0] jump_address;
  logic              exception;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus_4;
  logic              fetch_valid;
  logic              misaligned;

  // Requester side (pipeline control / testbench).
  modport master (
    output stall, branch_taken, branch_address, jump_taken, jump_address, exception,
    input  pc, pc_plus_4, fetch_valid, misaligned
  );

  // PC unit side.
  modport slave (
    input  stall, branch_taken, branch_address, jump_taken, jump_address, exception,
    output pc, pc_plus_4, fetch_valid, misaligned
  );

endinterface

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Purpose: priority select of the next fetch address plus redirect-target alignment check.
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is applied or parked.
// Ports: request strobes/targets, pending entry and pc+INC in; sel, next_addr, next_mis out.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF[ADDR_W-1:0],
  parameter int                INC        = INC_DEF
) (
  input  logic              exception,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              pend_mis,
  input  logic [ADDR_W-1:0] pc_inc,
  output sel_t              sel,
  output logic [ADDR_W-1:0] next_addr,
  output logic              next_mis
);

  // Low address bits that must be zero for an INC-aligned target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  logic br_mis;
  logic jmp_mis;

  assign br_mis  = (branch_address & ALIGN_MASK) != '0;
  assign jmp_mis = (jump_address & ALIGN_MASK) != '0;

  always_comb begin
    sel       = SEL_SEQ;
    next_addr = pc_inc;
    next_mis  = 1'b0;
    if (exception) begin
      // A plain exception is not a misaligned trap, so no pulse.
      sel       = SEL_EXC;
      next_addr = EXC_VECTOR;
    end else if (branch_taken) begin
      sel       = SEL_BR;
      next_addr = br_mis ? EXC_VECTOR : branch_address;
      next_mis  = br_mis;
    end else if (jump_taken) begin
      sel       = SEL_JMP;
      next_addr = jmp_mis ? EXC_VECTOR : jump_address;
      next_mis  = jmp_mis;
    end else if (pend_valid) begin
      // Pending entry already holds EXC_VECTOR if its target was misaligned.
      sel       = SEL_PEND;
      next_addr = pend_addr;
      next_mis  = pend_mis;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Purpose: fetch-stage program counter with branch/jump/exception redirect and stall buffering.
// Latency: one cycle from request to new pc; pc_plus_4 is combinational from pc.
// Backpressure: stall holds pc; a branch/jump arriving in a stall is parked and applied on release.
// Ports: clk, reset (sync, active-high), bus (fetch_pc_unit_if.slave).
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF[ADDR_W-1:0],
  parameter int                INC          = INC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  fetch_pc_unit_if.slave   bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              mis_q;

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_mis;
  logic              pend_is_br;

  sel_t              sel;
  logic [ADDR_W-1:0] next_addr;
  logic              next_mis;

  state_t            state;
  state_t            state_nxt;
  logic              fetch_valid_c;
  logic              redirect_req;

  assign pc_inc       = pc_q + ADDR_W'(INC);
  assign redirect_req = bus.branch_taken | bus.jump_taken;

  pc_next_sel #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR),
    .INC        (INC)
  ) u_pc_next_sel (
    .exception      (bus.exception),
    .branch_taken   (bus.branch_taken),
    .branch_address (bus.branch_address),
    .jump_taken     (bus.jump_taken),
    .jump_address   (bus.jump_address),
    .pend_valid     (pend_valid),
    .pend_addr      (pend_addr),
    .pend_mis       (pend_mis),
    .pc_inc         (pc_inc),
    .sel            (sel),
    .next_addr      (next_addr),
    .next_mis       (next_mis)
  );

  // pc, misaligned pulse and pending-redirect register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_mis   <= 1'b0;
      pend_is_br <= 1'b0;
    end else if (bus.exception) begin
      // Exception ignores stall and flushes anything parked.
      pc_q       <= EXC_VECTOR;
      mis_q      <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_mis   <= 1'b0;
      pend_is_br <= 1'b0;
    end else if (!bus.stall) begin
      // A fresh branch/jump outranks the parked entry, so the entry is
      // always consumed or discarded on a non-stalled edge.
      pc_q       <= next_addr;
      mis_q      <= next_mis;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_mis   <= 1'b0;
      pend_is_br <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      // Branch always replaces the parked entry; a jump only fills an empty
      // slot or replaces a parked jump, never a parked branch.
      if ((sel == SEL_BR) || ((sel == SEL_JMP) && !(pend_valid && pend_is_br))) begin
        pend_valid <= 1'b1;
        pend_addr  <= next_addr;
        pend_mis   <= next_mis;
        pend_is_br <= (sel == SEL_BR);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; fetch_valid follows the state register so it is low
  // exactly for the cycles that reset was sampled high.
  always_comb begin
    state_nxt     = state;
    fetch_valid_c = 1'b1;
    case (state)
      S_BOOT: begin
        fetch_valid_c = 1'b0;
        state_nxt     = S_RUN;
      end
      S_RUN: begin
        if (bus.stall && !bus.exception && redirect_req) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!bus.stall || bus.exception) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        fetch_valid_c = 1'b0;
        state_nxt     = S_BOOT;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus_4   = pc_inc;
  assign bus.fetch_valid = fetch_valid_c;
  assign bus.misaligned  = mis_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Purpose: directed-vector bench for fetch_pc_unit (32-bit default and 8-bit wrap instances).
// Latency: checks one edge after each stimulus step, sampled 1 time unit past the clock edge.
// Backpressure: stall windows are driven explicitly by the vectors.
module tb_fetch_pc_unit;

  logic clk;
  logic rst32;
  logic rst8;

  int n_vec = 0;
  int n_err = 0;

  fetch_pc_unit_if #(.ADDR_W(32)) bus32 ();
  fetch_pc_unit_if #(.ADDR_W(8))  bus8 ();

  fetch_pc_unit dut32 (
    .clk   (clk),
    .reset (rst32),
    .bus   (bus32.slave)
  );

  fetch_pc_unit #(
    .ADDR_W       (8),
    .RESET_VECTOR (8'h00),
    .EXC_VECTOR   (8'h80),
    .INC          (4)
  ) dut8 (
    .clk   (clk),
    .reset (rst8),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic stl, input logic br, input logic [31:0] ba,
                         input logic jp, input logic [31:0] ja, input logic ex);
    bus32.stall          = stl;
    bus32.branch_taken   = br;
    bus32.branch_address = ba;
    bus32.jump_taken     = jp;
    bus32.jump_address   = ja;
    bus32.exception      = ex;
  endtask

  task automatic idle32();
    drive32(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drive8(input logic stl, input logic br, input logic [7:0] ba);
    bus8.stall          = stl;
    bus8.branch_taken   = br;
    bus8.branch_address = ba;
    bus8.jump_taken     = 1'b0;
    bus8.jump_address   = 8'h00;
    bus8.exception      = 1'b0;
  endtask

  initial begin
    rst32 = 1'b1;
    rst8  = 1'b1;
    idle32();
    drive8(1'b0, 1'b0, 8'h00);
    tick();
    tick();

    // Reset state.
    check_vec("rst_pc",   bus32.pc,          32'h0);
    check_vec("rst_fv",   bus32.fetch_valid, 32'h0);
    check_vec("rst_mis",  bus32.misaligned,  32'h0);
    check_vec("rst_pc4",  bus32.pc_plus_4,   32'h4);

    // Free run after reset drops.
    rst32 = 1'b0;
    tick();
    check_vec("run0_pc", bus32.pc,          32'h4);
    check_vec("run0_fv", bus32.fetch_valid, 32'h1);
    tick();
    check_vec("run1_pc", bus32.pc, 32'h8);
    tick();
    check_vec("run2_pc", bus32.pc, 32'hC);
    check_vec("run2_pc4", bus32.pc_plus_4, 32'h10);

    // Reset mid-run, then come back to pc = 0x8.
    rst32 = 1'b1;
    tick();
    check_vec("rerst_pc", bus32.pc,          32'h0);
    check_vec("rerst_fv", bus32.fetch_valid, 32'h0);
    rst32 = 1'b0;
    tick();
    tick();
    check_vec("pre_br_pc", bus32.pc, 32'h8);

    // Branch to 0x100.
    drive32(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    tick();
    check_vec("br_pc", bus32.pc, 32'h100);
    idle32();
    tick();
    check_vec("br_seq_pc", bus32.pc, 32'h104);

    // Three-cycle stall with a jump parked mid-stall.
    drive32(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    check_vec("stl0_pc", bus32.pc, 32'h104);
    drive32(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    tick();
    check_vec("stl1_pc", bus32.pc, 32'h104);
    drive32(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    check_vec("stl2_pc", bus32.pc, 32'h104);
    idle32();
    tick();
    check_vec("rel_pc",  bus32.pc,         32'h200);
    check_vec("rel_mis", bus32.misaligned, 32'h0);
    tick();
    check_vec("rel_seq_pc", bus32.pc, 32'h204);

    // New branch in the release cycle beats the parked jump.
    drive32(1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    tick();
    check_vec("beat_stl_pc", bus32.pc, 32'h204);
    drive32(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    tick();
    check_vec("beat_pc", bus32.pc, 32'h600);
    idle32();
    tick();
    check_vec("beat_seq_pc", bus32.pc, 32'h604);

    // Branch overwrites a parked jump; a later jump is dropped.
    drive32(1'b1, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
    tick();
    drive32(1'b1, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
    tick();
    drive32(1'b1, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0);
    tick();
    check_vec("ovr_stl_pc", bus32.pc, 32'h604);
    idle32();
    tick();
    check_vec("ovr_pc", bus32.pc, 32'h800);
    tick();
    check_vec("ovr_seq_pc", bus32.pc, 32'h804);

    // Exception + branch + jump together: exception wins, nothing parked.
    drive32(1'b0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1);
    tick();
    check_vec("exc_pc",  bus32.pc,         32'h8000_0180);
    check_vec("exc_mis", bus32.misaligned, 32'h0);
    idle32();
    tick();
    check_vec("exc_seq_pc", bus32.pc, 32'h8000_0184);

    // Branch + jump together: branch wins, jump lost.
    drive32(1'b0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0);
    tick();
    check_vec("brjp_pc", bus32.pc, 32'h300);
    idle32();
    tick();
    check_vec("brjp_seq_pc", bus32.pc, 32'h304);

    // Exception during a stall flushes the parked branch.
    drive32(1'b1, 1'b1, 32'hA00, 1'b0, 32'h0, 1'b0);
    tick();
    drive32(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    check_vec("stlexc_pc", bus32.pc, 32'h8000_0180);
    drive32(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    check_vec("stlexc_hold_pc", bus32.pc, 32'h8000_0180);
    idle32();
    tick();
    check_vec("stlexc_rel_pc", bus32.pc, 32'h8000_0184);

    // Misaligned branch traps with a one-cycle pulse.
    drive32(1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
    tick();
    check_vec("misbr_pc",  bus32.pc,         32'h8000_0180);
    check_vec("misbr_mis", bus32.misaligned, 32'h1);
    idle32();
    tick();
    check_vec("misbr_mis_end", bus32.misaligned, 32'h0);
    check_vec("misbr_seq_pc",  bus32.pc,         32'h8000_0184);

    // Misaligned jump parked during a stall traps on release.
    drive32(1'b1, 1'b0, 32'h0, 1'b1, 32'h203, 1'b0);
    tick();
    check_vec("mispd_stl_mis", bus32.misaligned, 32'h0);
    check_vec("mispd_stl_pc",  bus32.pc,         32'h8000_0184);
    idle32();
    tick();
    check_vec("mispd_pc",  bus32.pc,         32'h8000_0180);
    check_vec("mispd_mis", bus32.misaligned, 32'h1);
    tick();
    check_vec("mispd_mis_end", bus32.misaligned, 32'h0);

    // Aligned jump: no trap.
    drive32(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
    tick();
    check_vec("jp_pc",  bus32.pc,         32'h1234_5678);
    check_vec("jp_mis", bus32.misaligned, 32'h0);
    idle32();

    // 8-bit instance: wrap from 0xFC to 0x00.
    rst8 = 1'b0;
    tick();
    check_vec("w8_boot_pc", {24'h0, bus8.pc}, 32'h04);
    drive8(1'b0, 1'b1, 8'hF8);
    tick();
    check_vec("w8_br_pc", {24'h0, bus8.pc}, 32'hF8);
    drive8(1'b0, 1'b0, 8'h00);
    tick();
    check_vec("w8_fc_pc",  {24'h0, bus8.pc},        32'hFC);
    check_vec("w8_fc_pc4", {24'h0, bus8.pc_plus_4}, 32'h00);
    tick();
    check_vec("w8_wrap_pc",  {24'h0, bus8.pc},    32'h00);
    check_vec("w8_wrap_mis", {31'h0, bus8.misaligned}, 32'h0);
    check_vec("w8_wrap_fv",  {31'h0, bus8.fetch_valid}, 32'h1);
    tick();
    check_vec("w8_seq_pc", {24'h0, bus8.pc}, 32'h04);

    // Reset while holding a parked branch clears it.
    drive8(1'b1, 1'b1, 8'h40);
    tick();
    check_vec("w8_hold_pc", {24'h0, bus8.pc}, 32'h04);
    drive8(1'b1, 1'b0, 8'h00);
    rst8 = 1'b1;
    tick();
    check_vec("w8_rst_pc", {24'h0, bus8.pc},          32'h00);
    check_vec("w8_rst_fv", {31'h0, bus8.fetch_valid}, 32'h0);
    rst8 = 1'b0;
    drive8(1'b0, 1'b0, 8'h00);
    tick();
    check_vec("w8_post_pc", {24'h0, bus8.pc},          32'h04);
    check_vec("w8_post_fv", {31'h0, bus8.fetch_valid}, 32'h1);
    tick();
    check_vec("w8_post_seq_pc", {24'h0, bus8.pc}, 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
